// File: rtl/if_fetch_queue.sv
// Instruction fetch queue between fetch and decode: a circular FIFO of {PC, instruction}
// pairs with a show-ahead head, flush on taken branch and a sticky overflow flag.
`timescale 1ns/1ps

module if_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [31:0]   PC_in,
  input  logic [31:0]   Instruction_in,
  input  logic          rd_en,
  input  logic          flush,
  output logic [31:0]   PC,
  output logic [31:0]   Instruction,
  output logic          valid,
  output logic          full,
  output logic [AW:0]   count,
  output logic          overflow
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE    = 1;
  localparam logic [AW-1:0] PTR_ONE    = 1;

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            overflow_q, overflow_d;
  logic            wr_accept, rd_accept;
  entry_t          head;

  // Status comes only from registered occupancy so freeze/valid never see input glitches.
  assign valid    = (count_q != '0);
  assign full     = (count_q == FULL_COUNT);
  assign count    = count_q;
  assign overflow = overflow_q;

  assign head        = mem_q[rd_ptr_q];
  assign PC          = valid ? head.pc    : 32'd0;
  assign Instruction = valid ? head.instr : 32'd0;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    rd_accept  = rd_en && valid && !flush;
    wr_accept  = wr_en && !flush && (!full || rd_accept);

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_accept) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_accept) rd_ptr_d = rd_ptr_q + PTR_ONE;
      unique case ({wr_accept, rd_accept})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
      if (wr_en && !wr_accept) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: storage has no reset; the outputs mask stale entries whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (wr_accept) mem_q[wr_ptr_q] <= '{pc: PC_in, instr: Instruction_in};
  end

`ifndef SYNTHESIS
  a_count_range: assert property (@(posedge clk) disable iff (!rst) count_q <= FULL_COUNT);
  a_ptr_span:    assert property (@(posedge clk) disable iff (!rst)
                                  (wr_ptr_q - rd_ptr_q) == count_q[AW-1:0]);
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Self-checking bench for if_fetch_queue: directed scenarios plus random traffic,
// all compared against a queue-based model of the fetch queue rules.
`timescale 1ns/1ps

module tb_if_fetch_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0;
  logic [31:0]   PC_in = '0;
  logic [31:0]   Instruction_in = '0;
  logic          rd_en = 1'b0;
  logic          flush = 1'b0;
  logic [31:0]   PC;
  logic [31:0]   Instruction;
  logic          valid;
  logic          full;
  logic [AW:0]   count;
  logic          overflow;

  int total = 0;
  int bad   = 0;

  logic [63:0] m_q[$];
  bit          m_ovf;

  if_fetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .PC_in(PC_in), .Instruction_in(Instruction_in),
    .rd_en(rd_en), .flush(flush), .PC(PC), .Instruction(Instruction), .valid(valid),
    .full(full), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [69:0] obs();
    return {valid, full, count, overflow, PC, Instruction};
  endfunction

  function automatic logic [69:0] exp_status();
    logic [63:0] h;
    h = (m_q.size() != 0) ? m_q[0] : 64'd0;
    return {m_q.size() != 0, m_q.size() == DEPTH, (AW+1)'(m_q.size()), m_ovf, h};
  endfunction

  task automatic model_step(input bit w, input logic [31:0] p, input logic [31:0] i,
                            input bit r, input bit f);
    bit rd_ok, wr_ok;
    if (f) begin
      m_q.delete();
    end else begin
      rd_ok = r && (m_q.size() > 0);
      wr_ok = w && ((m_q.size() < DEPTH) || rd_ok);
      if (w && !wr_ok) m_ovf = 1'b1;
      if (rd_ok) void'(m_q.pop_front());
      if (wr_ok) m_q.push_back({p, i});
    end
  endtask

  task automatic cycle(input bit w, input logic [31:0] p, input logic [31:0] i,
                       input bit r, input bit f);
    wr_en = w; PC_in = p; Instruction_in = i; rd_en = r; flush = f;
    @(posedge clk);
    model_step(w, p, i, r, f);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #2;
    m_q.delete();
    m_ovf = 1'b0;
    total++;
    if (obs() !== 70'd0) begin
      bad++;
      $display("FAIL reset_state: got=%h want=%h", obs(), 70'd0);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (obs() !== exp_status()) begin
      bad++;
      $display("FAIL reset_release: got=%h want=%h", obs(), exp_status());
    end
  endtask

  task automatic test_fill();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, 32'(k * 4), $urandom, 1'b0, 1'b0);
      total++;
      if (obs() !== exp_status()) begin
        bad++;
        $display("FAIL fill_step%0d: got=%h want=%h", k, obs(), exp_status());
      end
    end
    total++;
    if ({count, full, PC} !== {3'd4, 1'b1, 32'd0}) begin
      bad++;
      $display("FAIL fill_full: got count=%0d full=%0b pc=%h want 4 1 0", count, full, PC);
    end
    cycle(1'b1, 32'd16, $urandom, 1'b0, 1'b0);
    total++;
    if ({count, overflow} !== {3'd4, 1'b1} || obs() !== exp_status()) begin
      bad++;
      $display("FAIL fill_overflow: got=%h want=%h", obs(), exp_status());
    end
  endtask

  task automatic test_drain();
    for (int k = 0; k < 4; k++) begin
      total++;
      if (PC !== 32'(k * 4) || obs() !== exp_status()) begin
        bad++;
        $display("FAIL drain_head%0d: got pc=%h want pc=%h", k, PC, 32'(k * 4));
      end
      cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    end
    total++;
    if ({valid, count, PC, Instruction} !== '0) begin
      bad++;
      $display("FAIL drain_empty: got v=%0b cnt=%0d pc=%h ins=%h want all 0",
               valid, count, PC, Instruction);
    end
  endtask

  task automatic test_pass_through();
    logic [31:0] last_pc;
    do_reset();
    for (int k = 0; k < 4; k++) cycle(1'b1, 32'(k * 4), $urandom, 1'b0, 1'b0);
    cycle(1'b1, 32'd16, $urandom, 1'b1, 1'b0);
    total++;
    if ({count, overflow, PC} !== {3'd4, 1'b0, 32'd4} || obs() !== exp_status()) begin
      bad++;
      $display("FAIL pass_through: got cnt=%0d ovf=%0b pc=%h want 4 0 4", count, overflow, PC);
    end
    last_pc = '0;
    for (int k = 0; k < 4; k++) begin
      last_pc = PC;
      cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    end
    total++;
    if (last_pc !== 32'd16 || valid !== 1'b0) begin
      bad++;
      $display("FAIL pass_wrap: got last_pc=%h valid=%0b want 10 0", last_pc, valid);
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int k = 0; k < 3; k++) cycle(1'b1, $urandom, $urandom, 1'b0, 1'b0);
    cycle(1'b1, $urandom, $urandom, 1'b1, 1'b1);
    total++;
    if ({count, valid, overflow} !== '0 || obs() !== exp_status()) begin
      bad++;
      $display("FAIL flush_clear: got cnt=%0d v=%0b ovf=%0b want 0 0 0", count, valid, overflow);
    end
    cycle(1'b1, 32'h100, 32'hdead_beef, 1'b0, 1'b0);
    total++;
    if ({valid, count, PC, Instruction} !== {1'b1, 3'd1, 32'h100, 32'hdead_beef}) begin
      bad++;
      $display("FAIL flush_refill: got v=%0b cnt=%0d pc=%h ins=%h want 1 1 100 deadbeef",
               valid, count, PC, Instruction);
    end
  endtask

  task automatic test_empty_read();
    do_reset();
    cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    total++;
    if ({valid, count} !== '0 || obs() !== exp_status()) begin
      bad++;
      $display("FAIL empty_read: got v=%0b cnt=%0d want 0 0", valid, count);
    end
    cycle(1'b1, 32'h20, 32'h1234_5678, 1'b0, 1'b0);
    total++;
    if ({valid, PC, Instruction} !== {1'b1, 32'h20, 32'h1234_5678}) begin
      bad++;
      $display("FAIL empty_then_write: got v=%0b pc=%h ins=%h want 1 20 12345678",
               valid, PC, Instruction);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    cycle(1'b1, 32'h8, $urandom, 1'b0, 1'b0);
    cycle(1'b1, 32'hc, $urandom, 1'b0, 1'b0);
    #3;
    rst = 1'b0;
    #1;
    total++;
    if ({valid, count, PC} !== '0 || obs() !== 70'd0) begin
      bad++;
      $display("FAIL async_reset: got v=%0b cnt=%0d pc=%h want 0 0 0", valid, count, PC);
    end
    m_q.delete();
    m_ovf = 1'b0;
    #2;
    rst = 1'b1;
    cycle(1'b1, 32'h40, 32'h0bad_f00d, 1'b0, 1'b0);
    total++;
    if ({valid, count, PC} !== {1'b1, 3'd1, 32'h40} || obs() !== exp_status()) begin
      bad++;
      $display("FAIL reset_first_write: got=%h want=%h", obs(), exp_status());
    end
  endtask

  task automatic test_random();
    bit w, r, f;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      w = ($urandom_range(0, 9) < 6);
      r = ($urandom_range(0, 9) < 5);
      f = ($urandom_range(0, 19) == 0);
      cycle(w, $urandom, $urandom, r, f);
      total++;
      if (obs() !== exp_status()) begin
        bad++;
        $display("FAIL random_cycle%0d: got=%h want=%h", n, obs(), exp_status());
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_pass_through();
    test_flush();
    test_empty_read();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
